// File: rtl/uart_serial_link_if.sv
// Parser-side and pin-side signal bundle for uart_serial_link.
//   slave  : the transceiver (drives serial_tx, received bytes, ready and status pulses)
//   master : whatever drives the transceiver (board pin model / parser / bench)
// Signals:
//   serial_rx        serial input, idles high
//   serial_tx        serial output, idles high
//   uart_rxd         last good received byte
//   uart_rxd_strobe  one-cycle pulse per good byte
//   uart_txd         byte to transmit, sampled with uart_txd_strobe
//   uart_txd_strobe  one-cycle send request
//   uart_txd_ready   holding register empty
//   framing_error    one-cycle pulse, stop bit sampled low
//   tx_overflow      one-cycle pulse, send request dropped
interface uart_serial_link_if;
    logic       serial_rx;
    logic       serial_tx;
    logic [7:0] uart_rxd;
    logic       uart_rxd_strobe;
    logic [7:0] uart_txd;
    logic       uart_txd_strobe;
    logic       uart_txd_ready;
    logic       framing_error;
    logic       tx_overflow;

    modport slave (
        input  serial_rx, uart_txd, uart_txd_strobe,
        output serial_tx, uart_rxd, uart_rxd_strobe, uart_txd_ready,
               framing_error, tx_overflow
    );

    modport master (
        output serial_rx, uart_txd, uart_txd_strobe,
        input  serial_tx, uart_rxd, uart_rxd_strobe, uart_txd_ready,
               framing_error, tx_overflow
    );
endinterface

// File: rtl/uart_serial_link.sv
// 8N1 UART transceiver between the board serial pins and the command parser.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous active-high reset; aborts any frame in flight
//   bus    uart_serial_link_if.slave (serial pins, rx byte strobe, tx byte
//          strobe with ready flow control, framing_error / tx_overflow pulses)
// Parameter DIVISOR: clk cycles per bit, must be >= 8.
// RX and TX are fully independent; every output comes straight from a flop.
module uart_serial_link #(
    parameter int DIVISOR = 48
) (
    input  logic                clk,
    input  logic                reset,
    uart_serial_link_if.slave   bus
);
    localparam int CW = $clog2(DIVISOR) + 1;
    localparam logic [CW-1:0] HALF_BIT = CW'(DIVISOR / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    // ---------------- receiver ----------------
    rx_state_t     rx_state_r, rx_state_nxt_s;
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]    rx_bit_r;
    logic [7:0]    rx_shreg_r;
    logic [7:0]    rx_data_r;
    logic          rx_strobe_r, rx_ferr_r;
    logic          rx_fall_s, rx_tick_s, rx_shift_s, rx_good_s, rx_bad_s;

    assign rx_fall_s = rx_prev_r & ~rx_sync_r;
    assign rx_tick_s = (rx_cnt_r == {CW{1'b0}});

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= bus.serial_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
        end else begin
            rx_state_r <= rx_state_nxt_s;
        end
    end

    // RX next-state logic; every decision except BREAK exit is taken at mid-bit.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_fall_s) rx_state_nxt_s = RX_START;
                else           rx_state_nxt_s = RX_IDLE;
            end
            RX_START: begin
                if (rx_tick_s) rx_state_nxt_s = rx_sync_r ? RX_IDLE : RX_DATA;
                else           rx_state_nxt_s = RX_START;
            end
            RX_DATA: begin
                if (rx_tick_s && (rx_bit_r == 3'd7)) rx_state_nxt_s = RX_STOP;
                else                                  rx_state_nxt_s = RX_DATA;
            end
            RX_STOP: begin
                if (rx_tick_s) rx_state_nxt_s = rx_sync_r ? RX_IDLE : RX_BREAK;
                else           rx_state_nxt_s = RX_STOP;
            end
            RX_BREAK: begin
                if (rx_sync_r) rx_state_nxt_s = RX_IDLE;
                else           rx_state_nxt_s = RX_BREAK;
            end
            default: rx_state_nxt_s = RX_IDLE;
        endcase
    end

    // RX datapath controls decoded from the current state.
    always_comb begin
        rx_shift_s = 1'b0;
        rx_good_s  = 1'b0;
        rx_bad_s   = 1'b0;
        case (rx_state_r)
            RX_DATA: rx_shift_s = rx_tick_s;
            RX_STOP: begin
                rx_good_s = rx_tick_s & rx_sync_r;
                rx_bad_s  = rx_tick_s & ~rx_sync_r;
            end
            default: begin
                rx_shift_s = 1'b0;
                rx_good_s  = 1'b0;
                rx_bad_s   = 1'b0;
            end
        endcase
    end

    // RX baud counter, bit counter, shift register and registered outputs.
    // The counter sits at half a bit while idle so the first tick lands mid start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt_r    <= HALF_BIT;
            rx_bit_r    <= 3'd0;
            rx_shreg_r  <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_strobe_r <= 1'b0;
            rx_ferr_r   <= 1'b0;
        end else begin
            if ((rx_state_r == RX_IDLE) || (rx_state_r == RX_BREAK)) rx_cnt_r <= HALF_BIT;
            else if (rx_tick_s)                                       rx_cnt_r <= FULL_BIT;
            else                                                      rx_cnt_r <= rx_cnt_r - CNT_ONE;
            if (rx_state_r != RX_DATA) rx_bit_r <= 3'd0;
            else if (rx_shift_s)       rx_bit_r <= rx_bit_r + 3'd1;
            if (rx_shift_s) rx_shreg_r <= {rx_sync_r, rx_shreg_r[7:1]};
            if (rx_good_s)  rx_data_r  <= rx_shreg_r;
            rx_strobe_r <= rx_good_s;
            rx_ferr_r   <= rx_bad_s;
        end
    end

    assign bus.uart_rxd        = rx_data_r;
    assign bus.uart_rxd_strobe = rx_strobe_r;
    assign bus.framing_error   = rx_ferr_r;

    // ---------------- transmitter ----------------
    tx_state_t     tx_state_r, tx_state_nxt_s;
    logic [7:0]    tx_hold_r;
    logic          tx_ready_r;
    logic [9:0]    tx_shift_r;
    logic [CW-1:0] tx_cnt_r;
    logic [3:0]    tx_bit_r;
    logic          tx_ovf_r;
    logic          tx_accept_s, tx_end_s, tx_step_s, tx_load_s;

    assign tx_accept_s = bus.uart_txd_strobe & tx_ready_r;

    // TX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
        end else begin
            tx_state_r <= tx_state_nxt_s;
        end
    end

    // TX next-state logic; a full holding register at stop-bit end chains frames.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_load_s) tx_state_nxt_s = TX_SHIFT;
                else           tx_state_nxt_s = TX_IDLE;
            end
            TX_SHIFT: begin
                if (tx_end_s && !tx_load_s) tx_state_nxt_s = TX_IDLE;
                else                        tx_state_nxt_s = TX_SHIFT;
            end
            default: tx_state_nxt_s = TX_IDLE;
        endcase
    end

    // TX datapath controls: bit boundary, frame end and holding-to-shifter move.
    always_comb begin
        tx_end_s  = 1'b0;
        tx_step_s = 1'b0;
        tx_load_s = 1'b0;
        case (tx_state_r)
            TX_IDLE: tx_load_s = ~tx_ready_r;
            TX_SHIFT: begin
                tx_end_s  = (tx_cnt_r == {CW{1'b0}}) && (tx_bit_r == 4'd9);
                tx_step_s = (tx_cnt_r == {CW{1'b0}}) && (tx_bit_r != 4'd9);
                tx_load_s = tx_end_s & ~tx_ready_r;
            end
            default: begin
                tx_end_s  = 1'b0;
                tx_step_s = 1'b0;
                tx_load_s = 1'b0;
            end
        endcase
    end

    // Holding register, shifter (bit 0 drives the pin), baud counter, overflow pulse.
    // Accept needs ready=1 and load needs ready=0, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_hold_r  <= 8'h00;
            tx_ready_r <= 1'b1;
            tx_shift_r <= 10'h3FF;
            tx_cnt_r   <= {CW{1'b0}};
            tx_bit_r   <= 4'd0;
            tx_ovf_r   <= 1'b0;
        end else begin
            tx_ovf_r <= bus.uart_txd_strobe & ~tx_ready_r;
            if (tx_accept_s) begin
                tx_hold_r  <= bus.uart_txd;
                tx_ready_r <= 1'b0;
            end else if (tx_load_s) begin
                tx_ready_r <= 1'b1;
            end
            if (tx_load_s) begin
                tx_shift_r <= {1'b1, tx_hold_r, 1'b0};
                tx_cnt_r   <= FULL_BIT;
                tx_bit_r   <= 4'd0;
            end else if (tx_step_s) begin
                tx_shift_r <= {1'b1, tx_shift_r[9:1]};
                tx_cnt_r   <= FULL_BIT;
                tx_bit_r   <= tx_bit_r + 4'd1;
            end else if (tx_end_s) begin
                tx_shift_r <= 10'h3FF;
            end else if (tx_state_r == TX_SHIFT) begin
                tx_cnt_r <= tx_cnt_r - CNT_ONE;
            end
        end
    end

    assign bus.serial_tx      = tx_shift_r[0];
    assign bus.uart_txd_ready = tx_ready_r;
    assign bus.tx_overflow    = tx_ovf_r;
endmodule
